// File: rtl/llsc_ctrl_if.sv
// LL/SC sequencer bundle: MEM-stage request, snoop feed
// and the conditional-store bus port.
interface llsc_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_valid;
  logic [1:0]        mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              snoop_valid;
  logic [ADDR_W-1:0] snoop_addr;
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack;

  modport master (
    output mem_valid, mem_op, mem_addr, mem_wdata,
    output snoop_valid, snoop_addr, bus_ack,
    input  bus_req, bus_addr, bus_wdata
  );

  modport slave (
    input  mem_valid, mem_op, mem_addr, mem_wdata,
    input  snoop_valid, snoop_addr, bus_ack,
    output bus_req, bus_addr, bus_wdata
  );
endinterface

// File: rtl/llsc_ctrl.sv
// LL/SC sequencer: owns the link reservation, issues the
// conditional store and drives the LLbit write port.
module llsc_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int GRAN    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  llsc_ctrl_if.slave  bus,
  output logic        stall_o,
  output logic        sc_valid_o,
  output logic        sc_result_o,
  output logic        llbit_we_o,
  output logic        llbit_wdata_o
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SC_REQ,
    SC_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   link_valid_q, link_valid_d;
  logic [ADDR_W-1:GRAN]   link_addr_q, link_addr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   res_q, res_d;
  logic [ADDR_W-1:0]      baddr_q, baddr_d;
  logic [31:0]            bdata_q, bdata_d;
  logic                   llwe_q, llwe_d;
  logic                   llwd_q, llwd_d;

  logic is_ll, is_sc, snoop_hit, addr_hit, last;

  assign is_ll = bus.mem_valid && (bus.mem_op == 2'b01);
  assign is_sc = bus.mem_valid && (bus.mem_op == 2'b10);

  assign snoop_hit = link_valid_q && bus.snoop_valid &&
    (bus.snoop_addr[ADDR_W-1:GRAN] == link_addr_q);
  assign addr_hit = link_valid_q &&
    (bus.mem_addr[ADDR_W-1:GRAN] == link_addr_q);

  assign last = (TIMEOUT != 0) &&
    (cnt_q == CW'(TIMEOUT - 1));

  if (GRAN > 0) begin : g_unused
    logic unused_lo;
    assign unused_lo = ^{bus.mem_addr[GRAN-1:0],
                         bus.snoop_addr[GRAN-1:0]};
  end

  // State, link and latched-store registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      cnt_q        <= '0;
      res_q        <= 1'b0;
      baddr_q      <= '0;
      bdata_q      <= '0;
      llwe_q       <= 1'b0;
      llwd_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      baddr_q      <= baddr_d;
      bdata_q      <= bdata_d;
      llwe_q       <= llwe_d;
      llwd_q       <= llwd_d;
    end
  end

  // Next state: flush beats LL/SC/FSM, which beat snoops
  always_comb begin
    state_d      = state_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    baddr_d      = baddr_q;
    bdata_d      = bdata_q;
    llwe_d       = 1'b0;
    llwd_d       = 1'b0;
    if (flush) begin
      state_d      = IDLE;
      link_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_ll) begin
            link_addr_d  = bus.mem_addr[ADDR_W-1:GRAN];
            link_valid_d = 1'b1;
            llwe_d       = 1'b1;
            llwd_d       = 1'b1;
          end else if (is_sc) begin
            link_valid_d = 1'b0;
            llwe_d       = 1'b1;
            if (addr_hit && !snoop_hit) begin
              baddr_d = bus.mem_addr;
              bdata_d = bus.mem_wdata;
              cnt_d   = '0;
              state_d = SC_REQ;
            end else begin
              res_d   = 1'b0;
              state_d = SC_RESP;
            end
          end else if (snoop_hit) begin
            link_valid_d = 1'b0;
            llwe_d       = 1'b1;
          end
        end
        SC_REQ: begin
          if (bus.bus_ack) begin
            res_d   = 1'b1;
            state_d = SC_RESP;
          end else if (last) begin
            res_d   = 1'b0;
            state_d = SC_RESP;
          end else if (TIMEOUT != 0) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SC_RESP: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.bus_req   = (state_q == SC_REQ);
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_wdata = bdata_q;

  assign stall_o = (state_q == SC_REQ) ||
    ((state_q == IDLE) && is_sc && !flush);

  assign sc_valid_o  = (state_q == SC_RESP) && !flush;
  assign sc_result_o = sc_valid_o && res_q;

  assign llbit_we_o    = llwe_q;
  assign llbit_wdata_o = llwd_q;
endmodule

// File: tb/tb_llsc_ctrl.sv
// Scoreboard bench for llsc_ctrl: reservation model drives
// expectations, a negedge monitor checks DUT responses.
module tb_llsc_ctrl;
  localparam int AW = 32;
  localparam int GR = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic stall_o, sc_valid_o, sc_result_o;
  logic llbit_we_o, llbit_wdata_o;

  llsc_ctrl_if #(.ADDR_W(AW)) bif ();

  llsc_ctrl #(
    .ADDR_W(AW), .GRAN(GR), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .bus(bif),
    .stall_o(stall_o),
    .sc_valid_o(sc_valid_o),
    .sc_result_o(sc_result_o),
    .llbit_we_o(llbit_we_o),
    .llbit_wdata_o(llbit_wdata_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct { bit res; int cyc; } sc_exp_t;
  typedef struct { bit val; int cyc; } ll_exp_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int len;
    int cyc;
  } bus_exp_t;

  sc_exp_t  sc_q[$];
  ll_exp_t  ll_q[$];
  bus_exp_t bus_q[$];
  bit exp_stall = 1'b0;

  // Reservation model: one link granule, valid or not
  bit link_v = 1'b0;
  logic [AW-1:0] link_g = '0;

  // Monitor
  bus_exp_t cur;
  bit bus_act = 1'b0;
  int blen = 0;
  always @(negedge clk) begin
    if (rst) begin
      bus_act = 1'b0;
    end else begin
      check("stall", stall_o, exp_stall);
      if (sc_valid_o) begin
        if (sc_q.size() == 0) begin
          check("sc_unexpected", 1, 0);
        end else begin
          sc_exp_t e;
          e = sc_q.pop_front();
          check("sc_result", sc_result_o, e.res);
          check("sc_cycle", cyc, e.cyc);
        end
      end
      if (llbit_we_o) begin
        if (ll_q.size() == 0) begin
          check("llbit_unexpected", 1, 0);
        end else begin
          ll_exp_t e;
          e = ll_q.pop_front();
          check("llbit_wdata", llbit_wdata_o, e.val);
          check("llbit_cycle", cyc, e.cyc);
        end
      end
      if (bif.bus_req) begin
        if (!bus_act) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected", 1, 0);
            cur = '{a: '0, d: '0, len: 0, cyc: 0};
          end else begin
            cur = bus_q.pop_front();
            check("bus_start", cyc, cur.cyc);
          end
          bus_act = 1'b1;
          blen = 1;
        end else begin
          blen++;
        end
        check("bus_addr", bif.bus_addr, cur.a);
        check("bus_wdata", bif.bus_wdata, cur.d);
      end else if (bus_act) begin
        check("bus_len", blen, cur.len);
        bus_act = 1'b0;
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bif.mem_valid   = 1'b0;
    bif.mem_op      = 2'b00;
    bif.mem_addr    = $urandom;
    bif.mem_wdata   = $urandom;
    bif.snoop_valid = 1'b0;
    bif.snoop_addr  = $urandom;
    bif.bus_ack     = 1'b0;
    flush           = 1'b0;
  endtask

  function automatic bit g_eq(logic [AW-1:0] a,
                              logic [AW-1:0] g);
    return (a >> GR) == g;
  endfunction

  // Cycle with no LL/SC: optional snoop, optional flush
  task automatic gap(bit snp, logic [31:0] sa, bit fl);
    next();
    idle_in();
    exp_stall = 1'b0;
    bif.mem_valid = $urandom_range(0, 1);
    bif.mem_op = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
    bif.snoop_valid = snp;
    bif.snoop_addr = sa;
    if (fl) begin
      flush = 1'b1;
      link_v = 1'b0;
    end else if (snp && link_v && g_eq(sa, link_g)) begin
      link_v = 1'b0;
      ll_q.push_back('{val: 1'b0, cyc: cyc + 1});
    end
  endtask

  task automatic do_ll(logic [31:0] a, bit snp,
                       logic [31:0] sa);
    next();
    idle_in();
    exp_stall = 1'b0;
    bif.mem_valid = 1'b1;
    bif.mem_op = 2'b01;
    bif.mem_addr = a;
    bif.snoop_valid = snp;
    bif.snoop_addr = sa;
    link_v = 1'b1;
    link_g = a >> GR;
    ll_q.push_back('{val: 1'b1, cyc: cyc + 1});
  endtask

  // d: ack delay in SC_REQ cycles (>= TO: never acked)
  // fk: SC_REQ cycle index carrying a flush (-1: none)
  task automatic do_sc(logic [31:0] a, logic [31:0] d_in,
                       bit snp, logic [31:0] sa,
                       int d, int fk);
    int n, span;
    bit hit, ok;
    next();
    idle_in();
    exp_stall = 1'b1;
    bif.mem_valid = 1'b1;
    bif.mem_op = 2'b10;
    bif.mem_addr = a;
    bif.mem_wdata = d_in;
    bif.snoop_valid = snp;
    bif.snoop_addr = sa;
    n = cyc;
    hit = link_v && snp && g_eq(sa, link_g);
    ok = link_v && g_eq(a, link_g) && !hit;
    link_v = 1'b0;
    ll_q.push_back('{val: 1'b0, cyc: n + 1});
    if (!ok) begin
      sc_q.push_back('{res: 1'b0, cyc: n + 1});
      next();
      idle_in();
      exp_stall = 1'b0;
    end else begin
      if (fk >= 0) span = fk + 1;
      else span = (d < TO) ? d + 1 : TO;
      bus_q.push_back('{a: a, d: d_in, len: span,
                        cyc: n + 1});
      if (fk < 0)
        sc_q.push_back('{res: (d < TO), cyc: n + 1 + span});
      for (int k = 0; k < span; k++) begin
        next();
        idle_in();
        exp_stall = 1'b1;
        bif.mem_valid = 1'b1;
        bif.mem_op = 2'b10;
        bif.mem_addr = a;
        bif.mem_wdata = d_in;
        bif.snoop_valid = $urandom_range(0, 1);
        bif.snoop_addr = a;
        if (k == d) bif.bus_ack = 1'b1;
        if (k == fk) flush = 1'b1;
      end
      if (fk < 0) begin
        next();
        idle_in();
        exp_stall = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] pool [4];
    pool = '{32'h100, 32'h104, 32'h200, 32'h300};
    return pool[$urandom_range(0, 3)] |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    int n;
    idle_in();
    @(negedge clk);
    check("rst_bus_req", bif.bus_req, 0);
    check("rst_bus_addr", bif.bus_addr, 0);
    check("rst_bus_wdata", bif.bus_wdata, 0);
    check("rst_stall", stall_o, 0);
    check("rst_sc_valid", sc_valid_o, 0);
    check("rst_sc_result", sc_result_o, 0);
    check("rst_llbit_we", llbit_we_o, 0);
    check("rst_llbit_wdata", llbit_wdata_o, 0);
    next();
    rst = 1'b0;

    // Reset while the SC is waiting for its ack
    do_ll(32'h100, 0, 0);
    next();
    idle_in();
    exp_stall = 1'b1;
    bif.mem_valid = 1'b1;
    bif.mem_op = 2'b10;
    bif.mem_addr = 32'h100;
    bif.mem_wdata = 32'h12345678;
    n = cyc;
    link_v = 1'b0;
    ll_q.push_back('{val: 1'b0, cyc: n + 1});
    bus_q.push_back('{a: 32'h100, d: 32'h12345678,
                      len: 0, cyc: n + 1});
    next();
    idle_in();
    next();
    rst = 1'b1;
    exp_stall = 1'b0;
    #1;
    check("mid_rst_bus_req", bif.bus_req, 0);
    check("mid_rst_bus_addr", bif.bus_addr, 0);
    check("mid_rst_stall", stall_o, 0);
    check("mid_rst_sc_valid", sc_valid_o, 0);
    check("mid_rst_llbit_we", llbit_we_o, 0);
    next();
    rst = 1'b0;
    do_sc(32'h100, 32'h1, 0, 0, 0, -1);

    // Directed scenarios
    do_ll(32'h100, 0, 0);
    do_sc(32'h100, 32'hDEADBEEF, 0, 0, 1, -1);
    do_ll(32'h100, 0, 0);
    gap(1, 32'h102, 0);
    do_sc(32'h100, 32'h2, 0, 0, 0, -1);
    do_ll(32'h100, 0, 0);
    do_sc(32'h104, 32'h3, 0, 0, 0, -1);
    do_sc(32'h100, 32'h4, 0, 0, 0, -1);
    do_ll(32'h100, 0, 0);
    do_sc(32'h100, 32'h5, 0, 0, TO, -1);
    do_ll(32'h100, 0, 0);
    do_sc(32'h100, 32'h6, 0, 0, TO - 1, -1);
    do_ll(32'h100, 0, 0);
    do_sc(32'h100, 32'h7, 0, 0, TO, 1);
    gap(0, 0, 0);
    do_ll(32'h200, 1, 32'h200);
    gap(0, 0, 0);
    do_sc(32'h200, 32'h8, 0, 0, 0, -1);
    do_ll(32'h300, 0, 0);
    do_sc(32'h300, 32'h9, 1, 32'h301, 0, -1);
    do_ll(32'h300, 0, 0);
    gap(0, 0, 1);
    do_sc(32'h300, 32'hA, 0, 0, 0, -1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        do_ll(pick_addr(), $urandom_range(0, 1), pick_addr());
      end else if (kind < 7) begin
        int d, fk;
        d = $urandom_range(0, TO + 1);
        fk = -1;
        if ($urandom_range(0, 5) == 0 && d > 0)
          fk = $urandom_range(0, ((d < TO) ? d : TO) - 1);
        do_sc(pick_addr(), $urandom, $urandom_range(0, 1),
              pick_addr(), d, fk);
      end else begin
        gap($urandom_range(0, 1), pick_addr(),
            ($urandom_range(0, 7) == 0));
      end
    end

    for (int i = 0; i < 4; i++) gap(0, 0, 0);
    @(negedge clk);
    check("sc_q_drained", sc_q.size(), 0);
    check("ll_q_drained", ll_q.size(), 0);
    check("bus_q_drained", bus_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
